// File: rtl/xor_apuf_pkg.sv
// Shared types and helpers for the XOR-APUF evaluation sequencer.
package xor_apuf_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_WAIT,
    ST_REL,
    ST_DONE
  } state_t;

  function automatic int nwords(input int n);
    return n / WORD_W;
  endfunction

endpackage

// File: rtl/xor_apuf_eval_seq_if.sv
// Controller-side and PUF-side signals of the evaluation sequencer.
interface xor_apuf_eval_seq_if #(
  parameter int N = 64,
  parameter int K = 8
);
  logic         chal_en;
  logic         wr_en;
  logic [7:0]   word_id;
  logic [63:0]  data_in;
  logic         start;
  logic [N-1:0] challenge;
  logic         tig_signal;
  logic         puf_resp_ready;
  logic         puf_resp_bit;
  logic [K-1:0] puf_resp_bit_a;
  logic         busy;
  logic         resp_valid;
  logic         resp_bit;
  logic [K-1:0] resp_bits_a;
  logic [7:0]   ones_cnt;
  logic         timeout_err;

  modport master (
    output chal_en, wr_en, word_id, data_in, start,
           puf_resp_ready, puf_resp_bit, puf_resp_bit_a,
    input  challenge, tig_signal, busy, resp_valid, resp_bit,
           resp_bits_a, ones_cnt, timeout_err
  );

  modport slave (
    input  chal_en, wr_en, word_id, data_in, start,
           puf_resp_ready, puf_resp_bit, puf_resp_bit_a,
    output challenge, tig_signal, busy, resp_valid, resp_bit,
           resp_bits_a, ones_cnt, timeout_err
  );
endinterface

// File: rtl/puf_vote_acc.sv
// One-counters for the XOR response (index 0) and each chain, with majority vote.
module puf_vote_acc #(
  parameter int K    = 8,
  parameter int REPS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [K:0] i_bits,
  output logic [7:0] o_ones_cnt,
  output logic [K:0] o_maj
);
  localparam logic [7:0] HALF = 8'(REPS / 2);

  logic [7:0] w_cnt0;

  generate
    for (genvar gi = 0; gi <= K; gi++) begin : g_cnt
      logic [7:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_cnt <= '0;
        end else if (i_inc && i_bits[gi]) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      assign o_maj[gi] = (r_cnt > HALF);
      if (gi == 0) begin : g_xor
        assign w_cnt0 = r_cnt;
      end
    end
  endgenerate

  assign o_ones_cnt = w_cnt0;
endmodule

// File: rtl/xor_apuf_eval_seq.sv
// Challenge loader and repeated-evaluation sequencer for an N-bit, K-chain XOR-APUF.
module xor_apuf_eval_seq
  import xor_apuf_pkg::*;
#(
  parameter int N       = 64,
  parameter int K       = 8,
  parameter int REPS    = 11,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst,
  xor_apuf_eval_seq_if.slave bus
);
  localparam int NW      = nwords(N);
  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_rep, w_rep_next;
  logic          r_wr_d, r_start_d;
  logic          r_tig, r_busy, r_resp_valid, r_resp_bit, r_timeout_err;
  logic [K-1:0]  r_resp_bits_a;
  logic [7:0]    r_ones_cnt;
  logic          w_wr_edge, w_start_edge, w_idle_like, w_start_acc;
  logic          w_capture, w_timeout_hit, w_acc_clr;
  logic [K:0]    w_maj;
  logic [7:0]    w_acc_ones;

  assign w_wr_edge    = bus.wr_en & ~r_wr_d;
  assign w_start_edge = bus.start & ~r_start_d;
  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_acc  = bus.chal_en & w_start_edge & w_idle_like;
  assign w_acc_clr    = w_start_acc | ~bus.chal_en;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = '0;
    w_rep_next    = r_rep;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    if (!bus.chal_en) begin
      w_state_next = ST_IDLE;
      w_rep_next   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_edge) begin
            w_state_next = ST_ARM;
            w_rep_next   = '0;
          end
        end
        ST_ARM: begin
          if (r_cnt == CW'(SETTLE - 1)) w_state_next = ST_FIRE;
          else                          w_cnt_next   = r_cnt + 1'b1;
        end
        ST_FIRE: w_state_next = ST_WAIT;
        ST_WAIT: begin
          if (bus.puf_resp_ready) begin
            w_capture    = 1'b1;
            w_state_next = ST_REL;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_timeout_hit = 1'b1;
            w_state_next  = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_REL: begin
          if (!bus.puf_resp_ready) begin
            if (({1'b0, r_rep} + 9'd1) < 9'(REPS)) begin
              w_rep_next   = r_rep + 8'd1;
              w_state_next = ST_ARM;
            end else begin
              w_state_next = ST_DONE;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_wr_d    <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rep     <= w_rep_next;
      r_wr_d    <= bus.wr_en;
      r_start_d <= bus.start;
    end
  end

  // Word registers only accept writes between evaluations.
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      logic [WORD_W-1:0] r_word;
      always_ff @(posedge clk) begin
        if (rst || !bus.chal_en) begin
          r_word <= '0;
        end else if (w_wr_edge && w_idle_like && (bus.word_id == 8'(gi))) begin
          r_word <= bus.data_in;
        end
      end
      assign bus.challenge[gi*WORD_W +: WORD_W] = r_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tig         <= 1'b0;
      r_busy        <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_bit    <= 1'b0;
      r_resp_bits_a <= '0;
      r_ones_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (!bus.chal_en) begin
      r_tig         <= 1'b0;
      r_busy        <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_bit    <= 1'b0;
      r_resp_bits_a <= '0;
      r_ones_cnt    <= '0;
    end else begin
      r_tig <= (w_state_next == ST_FIRE) || (w_state_next == ST_WAIT);
      if (w_start_acc) begin
        r_busy        <= 1'b1;
        r_resp_valid  <= 1'b0;
        r_timeout_err <= 1'b0;
        r_resp_bit    <= 1'b0;
        r_resp_bits_a <= '0;
        r_ones_cnt    <= '0;
      end else if (r_state == ST_DONE) begin
        r_busy        <= 1'b0;
        r_resp_valid  <= 1'b1;
        r_resp_bit    <= w_maj[0];
        r_resp_bits_a <= w_maj[K:1];
        r_ones_cnt    <= w_acc_ones;
      end else if (w_timeout_hit) begin
        r_busy        <= 1'b0;
        r_timeout_err <= 1'b1;
      end
    end
  end

  puf_vote_acc #(.K(K), .REPS(REPS)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_acc_clr),
    .i_inc      (w_capture),
    .i_bits     ({bus.puf_resp_bit_a, bus.puf_resp_bit}),
    .o_ones_cnt (w_acc_ones),
    .o_maj      (w_maj)
  );

  assign bus.tig_signal  = r_tig;
  assign bus.busy        = r_busy;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_bit    = r_resp_bit;
  assign bus.resp_bits_a = r_resp_bits_a;
  assign bus.ones_cnt    = r_ones_cnt;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_xor_apuf_eval_seq.sv
// Directed bench for xor_apuf_eval_seq with a behavioural PUF responder.
module tb_xor_apuf_eval_seq;
  localparam int N = 128, K = 8, REPS = 11, SETTLE = 4, TIMEOUT = 1024;
  localparam logic [63:0] W0 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] W1 = 64'hFFFF_0000_AAAA_5555;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_apuf_eval_seq_if #(.N(N), .K(K)) ifc ();

  xor_apuf_eval_seq #(
    .N(N), .K(K), .REPS(REPS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int base     = 0;
  int xor_thr  = 6;
  bit never_ready = 1'b0;
  logic tig_prev  = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] id, input logic [63:0] d);
    ifc.word_id = id;
    ifc.data_in = d;
    ifc.wr_en   = 1'b1;
    tick;
    ifc.wr_en   = 1'b0;
    tick;
    $display("write word_id=%0d data=%h challenge=%h", id, d, ifc.challenge);
  endtask

  task automatic pulse_start;
    ifc.start = 1'b1;
    tick;
    ifc.start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!ifc.resp_valid && n < budget) begin
      tick;
      n++;
    end
    check_eq(tag, ifc.resp_valid, 1'b1);
    $display("eval %s cycles=%0d ones=%0d bit=%0b bits_a=%h fires=%0d",
             tag, n, ifc.ones_cnt, ifc.resp_bit, ifc.resp_bits_a, pulses - base);
  endtask

  function automatic logic [7:0] chain_pat(input int f);
    logic [7:0] v;
    v[0] = 1'b1;
    v[1] = 1'b0;
    v[2] = (f < 5);
    v[3] = (f < 6);
    v[4] = (f >= 5);
    v[5] = (f >= 6);
    v[6] = (f % 2 == 1);
    v[7] = (f % 2 == 0);
    return v;
  endfunction

  // PUF responder: ready follows trigger, response picked by fire index.
  initial begin
    int f;
    ifc.puf_resp_ready = 1'b0;
    ifc.puf_resp_bit   = 1'b0;
    ifc.puf_resp_bit_a = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ifc.tig_signal && !tig_prev) pulses++;
      tig_prev = ifc.tig_signal;
      if (ifc.tig_signal && !never_ready) begin
        f = pulses - base - 1;
        ifc.puf_resp_ready = 1'b1;
        ifc.puf_resp_bit   = (f < xor_thr);
        ifc.puf_resp_bit_a = chain_pat(f);
      end else begin
        ifc.puf_resp_ready = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int n;
    ifc.chal_en = 1'b0;
    ifc.wr_en   = 1'b0;
    ifc.word_id = '0;
    ifc.data_in = '0;
    ifc.start   = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    check_eq("rst_challenge", ifc.challenge, '0);
    check_eq("rst_tig", ifc.tig_signal, 1'b0);
    check_eq("rst_busy", ifc.busy, 1'b0);
    check_eq("rst_valid", ifc.resp_valid, 1'b0);
    check_eq("rst_ones", ifc.ones_cnt, 8'd0);
    check_eq("rst_timeout", ifc.timeout_err, 1'b0);
    rst = 1'b0;
    ifc.chal_en = 1'b1;
    tick;

    // Challenge assembly and out-of-range word index
    write_word(8'd0, W0);
    write_word(8'd1, W1);
    check_eq("chal_words", ifc.challenge, {W1, W0});
    write_word(8'd2, 64'h0123_4567_89AB_CDEF);
    check_eq("chal_oob", ifc.challenge, {W1, W0});

    // 6 of 11 ones: majority 1
    xor_thr = 6; never_ready = 1'b0; base = pulses;
    pulse_start;
    check_eq("eval1_busy", ifc.busy, 1'b1);
    wait_valid("eval1_done", 400, n);
    check_eq("eval1_latency", n, 78);
    check_eq("eval1_ones", ifc.ones_cnt, 8'd6);
    check_eq("eval1_bit", ifc.resp_bit, 1'b1);
    check_eq("eval1_bits_a", ifc.resp_bits_a, 8'h99);
    check_eq("eval1_fires", pulses - base, 11);
    check_eq("eval1_busy_end", ifc.busy, 1'b0);

    // 5 of 11 ones with start held high: one evaluation only
    xor_thr = 5; base = pulses;
    ifc.start = 1'b1;
    tick;
    wait_valid("eval2_done", 400, n);
    check_eq("eval2_ones", ifc.ones_cnt, 8'd5);
    check_eq("eval2_bit", ifc.resp_bit, 1'b0);
    check_eq("eval2_fires", pulses - base, 11);
    repeat (20) tick;
    check_eq("eval2_hold_fires", pulses - base, 11);
    check_eq("eval2_hold_valid", ifc.resp_valid, 1'b1);
    ifc.start = 1'b0;
    tick;

    // Write and start edges while busy are dropped
    xor_thr = 6; base = pulses;
    pulse_start;
    repeat (10) tick;
    write_word(8'd0, 64'h1111_2222_3333_4444);
    pulse_start;
    tick;
    check_eq("busy_write_drop", ifc.challenge, {W1, W0});
    wait_valid("eval3_done", 400, n);
    check_eq("eval3_fires", pulses - base, 11);
    check_eq("eval3_ones", ifc.ones_cnt, 8'd6);
    check_eq("eval3_challenge", ifc.challenge, {W1, W0});

    // Timeout: ready never arrives
    never_ready = 1'b1;
    pulse_start;
    n = 0;
    while (ifc.busy && n < 1200) begin
      tick;
      n++;
    end
    $display("timeout cycles=%0d err=%0b busy=%0b", n, ifc.timeout_err, ifc.busy);
    check_eq("to_busy", ifc.busy, 1'b0);
    check_eq("to_cycles", n, SETTLE + 1 + TIMEOUT);
    check_eq("to_err", ifc.timeout_err, 1'b1);
    check_eq("to_valid", ifc.resp_valid, 1'b0);
    check_eq("to_tig", ifc.tig_signal, 1'b0);
    ifc.chal_en = 1'b0;
    tick;
    check_eq("to_err_kept", ifc.timeout_err, 1'b1);
    check_eq("to_chal_clr", ifc.challenge, '0);
    ifc.chal_en = 1'b1;
    tick;

    // chal_en drop during WAIT
    write_word(8'd0, W0);
    base = pulses;
    pulse_start;
    repeat (20) tick;
    check_eq("abort_tig_pre", ifc.tig_signal, 1'b1);
    check_eq("abort_busy_pre", ifc.busy, 1'b1);
    ifc.chal_en = 1'b0;
    tick;
    check_eq("abort_tig", ifc.tig_signal, 1'b0);
    check_eq("abort_chal", ifc.challenge, '0);
    check_eq("abort_busy", ifc.busy, 1'b0);
    check_eq("abort_valid", ifc.resp_valid, 1'b0);
    ifc.chal_en = 1'b1;
    repeat (8) tick;
    check_eq("abort_idle_valid", ifc.resp_valid, 1'b0);
    check_eq("abort_idle_tig", ifc.tig_signal, 1'b0);
    check_eq("abort_idle_fires", pulses - base, 1);

    // Reset during FIRE, then a clean evaluation
    never_ready = 1'b0;
    write_word(8'd0, W0);
    write_word(8'd1, W1);
    pulse_start;
    repeat (SETTLE) tick;
    check_eq("fire_tig", ifc.tig_signal, 1'b1);
    rst = 1'b1;
    tick;
    check_eq("rstfire_chal", ifc.challenge, '0);
    check_eq("rstfire_tig", ifc.tig_signal, 1'b0);
    check_eq("rstfire_busy", ifc.busy, 1'b0);
    check_eq("rstfire_valid", ifc.resp_valid, 1'b0);
    check_eq("rstfire_ones", ifc.ones_cnt, 8'd0);
    rst = 1'b0;
    tick;
    write_word(8'd0, W0);
    write_word(8'd1, W1);
    xor_thr = 6; base = pulses;
    pulse_start;
    wait_valid("eval4_done", 400, n);
    check_eq("eval4_ones", ifc.ones_cnt, 8'd6);
    check_eq("eval4_bit", ifc.resp_bit, 1'b1);
    check_eq("eval4_fires", pulses - base, 11);
    check_eq("eval4_challenge", ifc.challenge, {W1, W0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
